// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 binary-code-modulation panel driver.
package hub75_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } state_e;

    // Bit positions of the six colour lines within one chain's slice of rgb/rd_data.
    localparam int R0 = 0;
    localparam int G0 = 1;
    localparam int B0 = 2;
    localparam int R1 = 3;
    localparam int G1 = 4;
    localparam int B1 = 5;

    localparam int CH_W    = 6;
    localparam int ABCDE_W = 5;

    function automatic int plane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Binary-weighted DISPLAY window timer: window length OE_BASE<<plane, oe_n gated by
// an optional brightness fraction when HUB75_BRIGHTNESS_EN is defined.
module hub75_oe_timer
    import hub75_pkg::*;
#(
    parameter int BIT_PLANES = 8,
    parameter int OE_BASE    = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           display,
    input  logic [plane_w(BIT_PLANES)-1:0] plane,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                     brightness,
`endif
    output logic                           done,
    output logic                           oe_n
);

    // Sized to hold the MSB plane's full window length without wrapping.
    localparam int LEN_MAX = OE_BASE << (BIT_PLANES - 1);
    localparam int CW      = $clog2(LEN_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len;
    logic [CW-1:0] on_len;

    assign len = CW'(OE_BASE) << plane;

`ifdef HUB75_BRIGHTNESS_EN
    logic [CW+8:0] prod;
    assign prod   = (CW+9)'(len) * (CW+9)'({1'b0, brightness} + 9'd1);
    assign on_len = CW'(prod >> 8);
`else
    assign on_len = len;
`endif

    assign done = display && (cnt_q == len - 1'b1);
    assign oe_n = !(display && (cnt_q < on_len));

    always_comb begin
        cnt_d = '0;
        if (display && !done) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/hub75_bcm_driver.sv
// HUB75 LED panel scan engine: shifts one row-pair per bit plane, latches, then shows
// it for a binary-weighted window. Optional brightness port via HUB75_BRIGHTNESS_EN.
module hub75_bcm_driver
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int SCAN_ROWS  = 32,
    parameter int BIT_PLANES = 8,
    parameter int CHAINS     = 1,
    parameter int OE_BASE    = 8
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            enable,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]                      brightness,
`endif
    output logic [$clog2(SCAN_ROWS*COLS)-1:0] rd_addr,
    output logic [plane_w(BIT_PLANES)-1:0]  rd_plane,
    input  logic [CH_W*CHAINS-1:0]          rd_data,
    output logic [CH_W*CHAINS-1:0]          rgb,
    output logic                            led_clk,
    output logic                            latch,
    output logic                            oe_n,
    output logic [ABCDE_W-1:0]              abcde,
    output logic                            frame_sync
);

    localparam int ADDR_W = $clog2(SCAN_ROWS * COLS);
    localparam int PW     = plane_w(BIT_PLANES);
    localparam int RW     = $clog2(SCAN_ROWS);
    localparam int SW     = $clog2(2 * COLS + 1);
    localparam int DW     = CH_W * CHAINS;

    localparam logic [SW-1:0]     SH_LAST    = SW'(2 * COLS);
    localparam logic [RW-1:0]     ROW_LAST   = RW'(SCAN_ROWS - 1);
    localparam logic [PW-1:0]     PLANE_LAST = PW'(BIT_PLANES - 1);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);

    state_e              state_q, state_d;
    logic [SW-1:0]       sh_cnt_q, sh_cnt_d;
    logic [RW-1:0]       row_q, row_d;
    logic [PW-1:0]       plane_q, plane_d;
    logic [DW-1:0]       rgb_q, rgb_d;
    logic [ABCDE_W-1:0]  abcde_q, abcde_d;
    logic [SW-2:0]       col;
    logic                sh_last;
    logic                in_display;
    logic                disp_done;

    assign col      = sh_cnt_q[SW-1:1];
    assign sh_last  = (sh_cnt_q == SH_LAST);
    assign rd_plane = plane_q;
    assign rgb      = rgb_q;
    assign abcde    = abcde_q;

    hub75_oe_timer #(
        .BIT_PLANES (BIT_PLANES),
        .OE_BASE    (OE_BASE)
    ) u_oe_timer (
        .clk        (clk),
        .resetn     (resetn),
        .display    (in_display),
        .plane      (plane_q),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .done       (disp_done),
        .oe_n       (oe_n)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            sh_cnt_q <= '0;
            row_q    <= '0;
            plane_q  <= '0;
            rgb_q    <= '0;
            abcde_q  <= '0;
        end else begin
            state_q  <= state_d;
            sh_cnt_q <= sh_cnt_d;
            row_q    <= row_d;
            plane_q  <= plane_d;
            rgb_q    <= rgb_d;
            abcde_q  <= abcde_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_cnt_d = '0;
        row_d    = row_q;
        plane_d  = plane_q;
        rgb_d    = rgb_q;
        abcde_d  = abcde_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_cnt_d = sh_cnt_q + 1'b1;
                // Odd cycles capture the pixel requested on the previous even cycle.
                if (sh_cnt_q[0]) rgb_d = rd_data;
                if (sh_last) begin
                    state_d  = ST_LATCH;
                    sh_cnt_d = '0;
                    // Row lines move only as LATCH begins, while the panel is blanked.
                    if (plane_q == '0) abcde_d = ABCDE_W'(row_q);
                end
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (disp_done) begin
                    state_d = enable ? ST_SHIFT : ST_IDLE;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        led_clk    = 1'b0;
        latch      = 1'b0;
        frame_sync = 1'b0;
        rd_addr    = '0;
        in_display = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                led_clk    = (sh_cnt_q != '0) && !sh_cnt_q[0];
                frame_sync = (sh_cnt_q == '0) && (row_q == '0) && (plane_q == '0);
                if (!sh_last) rd_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col);
            end
            ST_LATCH:   latch      = 1'b1;
            ST_DISPLAY: in_display = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Self-checking bench for hub75_bcm_driver (COLS=4, SCAN_ROWS=2, BIT_PLANES=2, OE_BASE=4).
module tb_hub75_bcm_driver;

    localparam int C  = 4;
    localparam int R  = 2;
    localparam int P  = 2;
    localparam int OB = 4;
    localparam int CH = 1;
    localparam int AW = $clog2(R * C);
    localparam int PW = 1;
    localparam int DW = 6 * CH;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_plane;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] rgb;
    logic          led_clk, latch, oe_n, frame_sync;
    logic [4:0]    abcde;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd255;
`endif

    hub75_bcm_driver #(
        .COLS(C), .SCAN_ROWS(R), .BIT_PLANES(P), .CHAINS(CH), .OE_BASE(OB)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
`ifdef HUB75_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .rd_addr    (rd_addr),
        .rd_plane   (rd_plane),
        .rd_data    (rd_data),
        .rgb        (rgb),
        .led_clk    (led_clk),
        .latch      (latch),
        .oe_n       (oe_n),
        .abcde      (abcde),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    // Framebuffer with one cycle of read latency.
    logic [DW-1:0] mem [P][R*C];
    always @(posedge clk) rd_data <= mem[rd_plane][rd_addr];

    typedef struct packed {
        logic [8:0]    ctl;      // {oe_n, latch, led_clk, frame_sync, abcde}
        logic          chk_rgb;
        logic [DW-1:0] rgb;
        logic          chk_addr;
        logic [AW-1:0] addr;
        logic [PW-1:0] plane;
    } exp_t;

    typedef struct {
        int n;
        int drop_k;
        int idle_n;
        int exp_busy;
        int exp_oe_low;
    } drop_vec_t;

    typedef struct {
        int bri;
        int exp_oe_low;
    } bri_vec_t;

    exp_t       exp_q[$];
    drop_vec_t  dv[4];
    bri_vec_t   bv[3];
    int         n_checks = 0;
    int         n_err = 0;
    int         m_row = 0;
    int         m_plane = 0;
    logic [4:0] m_abcde = '0;
    int         cur_bri = 255;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_oe_n"}, oe_n, 1);
        chk({tag, "_latch"}, latch, 0);
        chk({tag, "_led_clk"}, led_clk, 0);
        chk({tag, "_frame_sync"}, frame_sync, 0);
        chk({tag, "_abcde"}, abcde, 0);
        chk({tag, "_rgb"}, rgb, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_plane"}, rd_plane, 0);
    endtask

    task automatic fill_mem(input bit pattern);
        for (int p = 0; p < P; p++)
            for (int a = 0; a < R * C; a++)
                mem[p][a] = (pattern && p == 0) ? DW'(6'h01 << (a % C)) : DW'($urandom);
    endtask

    // Expected cycles for one (row, plane) slot: shift, latch, weighted display.
    task automatic push_slot(input int row, input int plane);
        exp_t e;
        int   len, on;
        len = OB << plane;
        on  = (len * (cur_bri + 1)) >> 8;
        for (int k = 0; k <= 2 * C; k++) begin
            e = '0;
            e.ctl = {1'b1, 1'b0, (k > 0 && k % 2 == 0), (k == 0 && row == 0 && plane == 0), m_abcde};
            if (k % 2 == 0 && k < 2 * C) begin
                e.chk_addr = 1'b1;
                e.addr     = AW'(row * C + k / 2);
                e.plane    = PW'(plane);
            end
            if (k > 0 && k % 2 == 0) begin
                e.chk_rgb = 1'b1;
                e.rgb     = mem[plane][row * C + k / 2 - 1];
            end
            exp_q.push_back(e);
        end
        if (plane == 0) m_abcde = 5'(row);
        e = '0;
        e.ctl = {1'b1, 1'b1, 1'b0, 1'b0, m_abcde};
        exp_q.push_back(e);
        for (int d = 0; d < len; d++) begin
            e = '0;
            e.ctl = {(d >= on), 3'b000, m_abcde};
            exp_q.push_back(e);
        end
    endtask

    task automatic run_slots(input int n, input int drop_k, input int idle_n,
                             output int oe_low, output int busy,
                             output int first_fs, output int fs_period);
        int         drop_at;
        int         last_fs;
        exp_t       e;
        logic [8:0] act_ctl;
        exp_q.delete();
        drop_at = -1;
        for (int s = 0; s < n; s++) begin
            if (s == n - 1 && drop_k >= 0) drop_at = exp_q.size() + drop_k;
            push_slot(m_row, m_plane);
            m_plane++;
            if (m_plane == P) begin
                m_plane = 0;
                m_row   = (m_row + 1) % R;
            end
        end
        for (int i = 0; i < idle_n; i++) begin
            e = '0;
            e.ctl = {1'b1, 3'b000, m_abcde};
            exp_q.push_back(e);
        end
        oe_low = 0; busy = 0; first_fs = -1; fs_period = -1; last_fs = -1;
        enable = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            e       = exp_q[i];
            act_ctl = {oe_n, latch, led_clk, frame_sync, abcde};
            chk($sformatf("ctl[%0d]", i), act_ctl, e.ctl);
            if (e.chk_rgb)  chk($sformatf("rgb[%0d]", i), rgb, e.rgb);
            if (e.chk_addr) chk($sformatf("addr[%0d]", i), {rd_plane, rd_addr}, {e.plane, e.addr});
            if (oe_n === 1'b0) begin
                oe_low++;
                busy = i + 1;
            end
            if (frame_sync === 1'b1) begin
                if (first_fs < 0) first_fs = i;
                if (last_fs >= 0) fs_period = i - last_fs;
                last_fs = i;
            end
            if (i == drop_at) enable = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ol, busy, ffs, fper;

        // Drop scenarios: {slots, drop offset in last slot, idle cycles, busy cycles, oe low cycles}
        dv[0] = '{3,  3, 5, 46, 16};   // drop in SHIFT of row 1 plane 0
        dv[1] = '{1,  9, 4, 18,  8};   // drop in LATCH of row 1 plane 1
        dv[2] = '{2, 17, 3, 32, 12};   // drop on the last DISPLAY cycle
        dv[3] = '{1,  0, 2, 14,  4};   // drop on the first SHIFT cycle
        bv[0] = '{127, 24};
        bv[1] = '{255, 48};
        bv[2] = '{0,    0};

        fill_mem(1'b1);
        resetn = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("init");
        resetn = 1'b1;

        run_slots(8, -1, 0, ol, busy, ffs, fper);
        chk("run_first_fs", ffs, 0);
        chk("run_fs_period", fper, 64);
        chk("run_oe_low", ol, 48);

        for (int t = 0; t < 4; t++) begin
            fill_mem(1'b0);
            run_slots(dv[t].n, dv[t].drop_k, dv[t].idle_n, ol, busy, ffs, fper);
            chk($sformatf("drop%0d_busy", t), busy, dv[t].exp_busy);
            chk($sformatf("drop%0d_oe_low", t), ol, dv[t].exp_oe_low);
        end

        // Reset while row 1 plane 1 is on display.
        enable = 1'b1;
        repeat (13) @(negedge clk);
        chk("pre_rst_oe_n", oe_n, 0);
        chk("pre_rst_abcde", abcde, 1);
        resetn = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk_reset("mid");
        resetn  = 1'b1;
        m_row   = 0;
        m_plane = 0;
        m_abcde = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_idle_oe_n", oe_n, 1);
        end
        run_slots(4, -1, 0, ol, busy, ffs, fper);
        chk("rst_first_fs", ffs, 0);
        chk("rst_oe_low", ol, 24);

`ifdef HUB75_BRIGHTNESS_EN
        for (int t = 0; t < 3; t++) begin
            fill_mem(1'b0);
            brightness = 8'(bv[t].bri);
            cur_bri    = bv[t].bri;
            run_slots(8, -1, 0, ol, busy, ffs, fper);
            chk($sformatf("bri%0d_oe_low", bv[t].bri), ol, bv[t].exp_oe_low);
            chk($sformatf("bri%0d_fs_period", bv[t].bri), fper, 64);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
